// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_HOLD = 2'b10
    } fetch_state_e;

    // Next-PC choice made at the moment an instruction is consumed
    typedef enum logic [1:0] {
        PC_SEL_KEEP   = 2'b00,
        PC_SEL_INC    = 2'b01,
        PC_SEL_TARGET = 2'b10
    } pc_sel_e;

    // PC loaded out of reset unless the instance overrides it
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    // Instruction word field layout seen by decode / unit_control
    localparam int IR_W        = 32;
    localparam int IR_TYPE_MSB = 31;
    localparam int IR_TYPE_LSB = 29;
    localparam int IR_OP_MSB   = 28;
    localparam int IR_OP_LSB   = 24;
    localparam int TYPE_W      = IR_TYPE_MSB - IR_TYPE_LSB + 1;
    localparam int OP_W        = IR_OP_MSB - IR_OP_LSB + 1;

    // Encoding of the ADD instruction (ALU type, add operation)
    localparam logic [TYPE_W-1:0] TYPE_ALU = 3'b001;
    localparam logic [OP_W-1:0]   OP_ADD   = 5'b00010;

    // Extract the instruction type field
    function automatic logic [TYPE_W-1:0] ir_type(input logic [IR_W-1:0] ir);
        return ir[IR_TYPE_MSB:IR_TYPE_LSB];
    endfunction

    // Extract the operation field
    function automatic logic [OP_W-1:0] ir_op(input logic [IR_W-1:0] ir);
        return ir[IR_OP_MSB:IR_OP_LSB];
    endfunction

    // Translate the unit_control PC controls into a next-PC choice
    function automatic pc_sel_e decode_pc_sel(input logic w_pc, input logic s_mxpc);
        if (!w_pc) begin
            return PC_SEL_KEEP;
        end
        return s_mxpc ? PC_SEL_TARGET : PC_SEL_INC;
    endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter register with its next-PC mux and incrementer.
// The PC only moves on cycles where the fetch unit reports that the current
// instruction was consumed; otherwise it holds regardless of the controls.
module instr_fetch_pc_reg
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    input  logic        w_pc,
    input  logic        s_mxpc,
    input  logic [31:0] pc_target,
    output logic [31:0] pc
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_inc;
    pc_sel_e     pc_sel;

    // Sequential incrementer; wraps naturally from all-ones back to zero
    always_comb begin
        pc_inc = pc_q + 32'd1;
    end

    // Choose the next PC, but only when an instruction is being consumed
    always_comb begin
        pc_sel = decode_pc_sel(w_pc, s_mxpc);
        pc_d   = pc_q;
        if (advance) begin
            case (pc_sel)
                PC_SEL_TARGET: pc_d = pc_target;
                PC_SEL_INC:    pc_d = pc_inc;
                default:       pc_d = pc_q;
            endcase
        end
    end

    // PC register with synchronous reset to the reset vector
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests the word at PC from instruction memory,
// latches it into IR, holds it until decode consumes it, then advances PC
// according to unit_control and fetches again.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              CLK,
    input  logic              RST,
    output logic [31:0]       IM_ADDR,
    output logic              IM_REQ,
    input  logic [31:0]       IM_RDATA,
    input  logic              IM_ACK,
    output logic [31:0]       IR,
    output logic [2:0]        TYPE,
    output logic [4:0]        OP,
    output logic              IR_VALID,
    input  logic              IR_TAKE,
    input  logic              W_PC,
    input  logic              S_MXPC,
    input  logic [31:0]       PC_TARGET,
    output logic [31:0]       PC,
    output logic [CNT_W-1:0]  FETCH_CNT
);

    fetch_state_e     state_q;
    fetch_state_e     state_d;
    logic [31:0]      ir_q;
    logic [31:0]      ir_d;
    logic             ir_valid_q;
    logic             ir_valid_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ack_accept;
    logic             take_fire;
    logic             im_req;
    logic [31:0]      pc;

    // Acknowledges only count while a request is outstanding, and a take
    // only counts while a valid instruction is being held
    always_comb begin
        ack_accept = (state_q == ST_REQ) && IM_ACK;
        take_fire  = (state_q == ST_HOLD) && ir_valid_q && IR_TAKE;
    end

    // State register; reset wins over any same-cycle ack or take
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: idle for one cycle after reset, then request/hold loop
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ:  if (ack_accept) state_d = ST_HOLD;
            ST_HOLD: if (take_fire)  state_d = ST_REQ;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: the request is a pure function of state so the address
    // and request stay stable for the whole wait on memory
    always_comb begin
        im_req = 1'b0;
        case (state_q)
            ST_REQ:  im_req = 1'b1;
            default: im_req = 1'b0;
        endcase
    end

    // Instruction register, valid flag and consumed-instruction counter
    always_comb begin
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        cnt_d      = cnt_q;
        if (ack_accept) begin
            ir_d       = IM_RDATA;
            ir_valid_d = 1'b1;
        end
        if (take_fire) begin
            ir_valid_d = 1'b0;
            cnt_d      = cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    instr_fetch_pc_reg #(
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .clk       (CLK),
        .rst       (RST),
        .advance   (take_fire),
        .w_pc      (W_PC),
        .s_mxpc    (S_MXPC),
        .pc_target (PC_TARGET),
        .pc        (pc)
    );

    assign IM_REQ    = im_req;
    assign IM_ADDR   = pc;
    assign PC        = pc;
    assign IR        = ir_q;
    assign IR_VALID  = ir_valid_q;
    assign TYPE      = ir_type(ir_q);
    assign OP        = ir_op(ir_q);
    assign FETCH_CNT = cnt_q;

endmodule
